// File: rtl/score_keeper_pkg.sv
// Shared types and constants for the two-player scoreboard.
package score_pkg;

  typedef enum logic {
    PLAY = 1'b0,
    DONE = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    WIN_NONE  = 2'b00,
    WIN_LEFT  = 2'b01,
    WIN_RIGHT = 2'b10
  } winner_e;

  localparam logic [7:0] SCORE_MAX = 8'd255;

  // Signed 9-bit lead of a over b; never underflows for 8-bit scores.
  function automatic logic signed [8:0] score_lead(input logic [7:0] a, input logic [7:0] b);
    return $signed({1'b0, a}) - $signed({1'b0, b});
  endfunction

endpackage

// File: rtl/score_keeper_debounce.sv
// Button conditioner: 2-FF synchronizer, run-length debounce, rising-edge press pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam logic [23:0] CNT_LAST = 24'(DEBOUNCE_CYCLES - 1);

  logic        sync1_q, sync2_q;
  logic        stable_q, stable_d;
  logic        stable_dly_q;
  logic [23:0] cnt_q, cnt_d;
  logic        press_q, press_d;

  // Count consecutive disagreeing cycles; flip the stable level on the last one.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = ~stable_q;
      end else begin
        cnt_d = cnt_q + 24'd1;
      end
    end
    press_d = stable_q & ~stable_dly_q;
  end

  // Synchronizer, debounce state and edge-detect registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      cnt_q        <= '0;
      press_q      <= 1'b0;
    end else begin
      sync1_q      <= btn_raw;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      cnt_q        <= cnt_d;
      press_q      <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/score_keeper.sv
// Two-player win-by-two scoreboard feeding the seven-segment display driver.
module score_keeper
  import score_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned WIN_SCORE       = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_clear,
  output logic [7:0] num_left,
  output logic [7:0] num_right,
  output logic [1:0] winner,
  output logic       point
);

  localparam logic [7:0] WIN_Q = 8'(WIN_SCORE);

  logic       press_left, press_right, press_clear;
  state_e     state_q, state_d;
  logic [7:0] num_left_q, num_left_d;
  logic [7:0] num_right_q, num_right_d;
  winner_e    winner_q, winner_d;
  logic       point_q, point_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .clk(clk), .rst(rst), .btn_raw(btn_left), .press(press_left)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .clk(clk), .rst(rst), .btn_raw(btn_right), .press(press_right)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk(clk), .rst(rst), .btn_raw(btn_clear), .press(press_clear)
  );

  // Next state: clear beats everything, simultaneous points cancel, win check on new scores.
  always_comb begin
    state_d     = state_q;
    num_left_d  = num_left_q;
    num_right_d = num_right_q;
    winner_d    = winner_q;
    point_d     = 1'b0;
    if (press_clear) begin
      state_d     = PLAY;
      num_left_d  = '0;
      num_right_d = '0;
      winner_d    = WIN_NONE;
    end else if (press_left && press_right) begin
      point_d = 1'b0;
    end else if (state_q == PLAY) begin
      if (press_left && num_left_q != SCORE_MAX) begin
        num_left_d = num_left_q + 8'd1;
        point_d    = 1'b1;
        if (num_left_d >= WIN_Q && score_lead(num_left_d, num_right_q) >= 9'sd2) begin
          state_d  = DONE;
          winner_d = WIN_LEFT;
        end
      end else if (press_right && num_right_q != SCORE_MAX) begin
        num_right_d = num_right_q + 8'd1;
        point_d     = 1'b1;
        if (num_right_d >= WIN_Q && score_lead(num_right_d, num_left_q) >= 9'sd2) begin
          state_d  = DONE;
          winner_d = WIN_RIGHT;
        end
      end
    end
  end

  // Game state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= PLAY;
      num_left_q  <= '0;
      num_right_q <= '0;
      winner_q    <= WIN_NONE;
      point_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_left_q  <= num_left_d;
      num_right_q <= num_right_d;
      winner_q    <= winner_d;
      point_q     <= point_d;
    end
  end

  assign num_left  = num_left_q;
  assign num_right = num_right_q;
  assign winner    = winner_q;
  assign point     = point_q;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench: two instances (WIN_SCORE 11 and 254) driven by the same buttons.
module tb_score_keeper;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       bl = 1'b0, br = 1'b0, bc = 1'b0;
  logic [7:0] nl [2];
  logic [7:0] nr [2];
  logic [1:0] w  [2];
  logic       p  [2];

  int vectors    = 0;
  int miscompares = 0;

  // Reference model at press level.
  int ml [2], mr [2], mw [2], mp [2];
  bit mdone [2];
  int win_of [2] = '{11, 254};

  always #5 clk = ~clk;

  score_keeper #(.DEBOUNCE_CYCLES(D), .WIN_SCORE(11)) dut0 (
    .clk(clk), .rst(rst), .btn_left(bl), .btn_right(br), .btn_clear(bc),
    .num_left(nl[0]), .num_right(nr[0]), .winner(w[0]), .point(p[0])
  );
  score_keeper #(.DEBOUNCE_CYCLES(D), .WIN_SCORE(254)) dut1 (
    .clk(clk), .rst(rst), .btn_left(bl), .btn_right(br), .btn_clear(bc),
    .num_left(nl[1]), .num_right(nr[1]), .winner(w[1]), .point(p[1])
  );

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      ml[i] = 0; mr[i] = 0; mw[i] = 0; mp[i] = 0; mdone[i] = 1'b0;
    end
  endfunction

  function automatic void model_apply(bit l, bit r, bit c);
    for (int i = 0; i < 2; i++) begin
      mp[i] = 0;
      if (c) begin
        ml[i] = 0; mr[i] = 0; mw[i] = 0; mdone[i] = 1'b0;
      end else if (l && r) begin
        mp[i] = 0;
      end else if (!mdone[i]) begin
        if (l && ml[i] < 255) begin
          ml[i]++; mp[i] = 1;
          if (ml[i] >= win_of[i] && ml[i] - mr[i] >= 2) begin mdone[i] = 1'b1; mw[i] = 1; end
        end else if (r && mr[i] < 255) begin
          mr[i]++; mp[i] = 1;
          if (mr[i] >= win_of[i] && mr[i] - ml[i] >= 2) begin mdone[i] = 1'b1; mw[i] = 2; end
        end
      end
    end
  endfunction

  // One button gesture: optional bounce, clean hold, release; cycle-exact update check.
  task automatic press(input bit l, input bit r, input bit c, input int pairs);
    int ol [2], orr [2], ow [2];
    int el, er, ew, ep;
    @(negedge clk);
    for (int i = 0; i < pairs; i++) begin
      bl = l; br = r; bc = c;
      repeat (2) @(negedge clk);
      bl = 1'b0; br = 1'b0; bc = 1'b0;
      repeat (2) @(negedge clk);
      for (int j = 0; j < 2; j++) begin
        vectors++;
        if (p[j] !== 1'b0) begin
          miscompares++;
          $display("FAIL bounce_point inst%0d: point=%b required 0", j, p[j]);
        end
      end
    end
    bl = l; br = r; bc = c;
    for (int j = 0; j < 2; j++) begin ol[j] = ml[j]; orr[j] = mr[j]; ow[j] = mw[j]; end
    model_apply(l, r, c);
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      for (int j = 0; j < 2; j++) begin
        if (k < 3 + D) begin el = ol[j]; er = orr[j]; ew = ow[j]; ep = 0; end
        else begin el = ml[j]; er = mr[j]; ew = mw[j]; ep = (k == 3 + D) ? mp[j] : 0; end
        vectors++;
        if (nl[j] !== 8'(el) || nr[j] !== 8'(er) || w[j] !== 2'(ew) || p[j] !== 1'(ep)) begin
          miscompares++;
          $display("FAIL press_edge%0d inst%0d: got %0d-%0d w=%b p=%b required %0d-%0d w=%0d p=%0d",
                   k, j, nl[j], nr[j], w[j], p[j], el, er, ew, ep);
        end
      end
    end
    @(negedge clk);
    bl = 1'b0; br = 1'b0; bc = 1'b0;
    repeat (2 * D + 4) begin
      @(posedge clk); #1;
      for (int j = 0; j < 2; j++) begin
        vectors++;
        if (p[j] !== 1'b0) begin
          miscompares++;
          $display("FAIL release_point inst%0d: point=%b required 0", j, p[j]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; bl = 1'b0; br = 1'b0; bc = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int j = 0; j < 2; j++) begin
      vectors++;
      if (nl[j] !== 8'd0 || nr[j] !== 8'd0 || w[j] !== 2'b00 || p[j] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_values inst%0d: got %0d-%0d w=%b p=%b required 0-0 w=00 p=0",
                 j, nl[j], nr[j], w[j], p[j]);
      end
    end
  endtask

  task automatic test_debounce();
    press(1, 0, 0, 5);
    vectors++;
    if (nl[0] !== 8'd1) begin
      miscompares++;
      $display("FAIL debounce_score: num_left=%0d required 1", nl[0]);
    end
  endtask

  task automatic test_async_reset();
    press(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) press(1, 0, 0, 0);
    vectors++;
    if (nl[0] !== 8'd5) begin
      miscompares++;
      $display("FAIL midgame_score: num_left=%0d required 5", nl[0]);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (nl[0] !== 8'd0 || nl[1] !== 8'd0 || w[0] !== 2'b00) begin
      miscompares++;
      $display("FAIL async_reset: num_left=%0d/%0d winner=%b required 0/0 00", nl[0], nl[1], w[0]);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_simultaneous();
    press(0, 0, 1, 0);
    press(1, 0, 0, 1);
    press(1, 1, 0, 2);
    press(1, 1, 0, 0);
    vectors++;
    if (nl[0] !== 8'd1 || nr[0] !== 8'd0) begin
      miscompares++;
      $display("FAIL both_discard: got %0d-%0d required 1-0", nl[0], nr[0]);
    end
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    press(1, 0, 1, 1);
    vectors++;
    if (nl[0] !== 8'd0 || nr[0] !== 8'd0) begin
      miscompares++;
      $display("FAIL left_clear: got %0d-%0d required 0-0", nl[0], nr[0]);
    end
  endtask

  task automatic test_win_by_two();
    press(0, 0, 1, 0);
    for (int i = 0; i < 10; i++) begin press(1, 0, 0, 0); press(0, 1, 0, 0); end
    press(1, 0, 0, 0);
    vectors++;
    if (nl[0] !== 8'd11 || nr[0] !== 8'd10 || w[0] !== 2'b00) begin
      miscompares++;
      $display("FAIL deuce_11_10: got %0d-%0d w=%b required 11-10 w=00", nl[0], nr[0], w[0]);
    end
    press(1, 0, 0, 0);
    vectors++;
    if (nl[0] !== 8'd12 || nr[0] !== 8'd10 || w[0] !== 2'b01) begin
      miscompares++;
      $display("FAIL win_12_10: got %0d-%0d w=%b required 12-10 w=01", nl[0], nr[0], w[0]);
    end
    press(0, 1, 0, 0);
    vectors++;
    if (nl[0] !== 8'd12 || nr[0] !== 8'd10) begin
      miscompares++;
      $display("FAIL done_frozen: got %0d-%0d required 12-10", nl[0], nr[0]);
    end
    press(0, 0, 1, 1);
    vectors++;
    if (nl[0] !== 8'd0 || nr[0] !== 8'd0 || w[0] !== 2'b00) begin
      miscompares++;
      $display("FAIL clear_after_win: got %0d-%0d w=%b required 0-0 w=00", nl[0], nr[0], w[0]);
    end
  endtask

  task automatic test_straight_win();
    press(0, 0, 1, 0);
    for (int i = 0; i < 9; i++) press(0, 1, 0, 0);
    for (int i = 0; i < 10; i++) press(1, 0, 0, 0);
    vectors++;
    if (w[0] !== 2'b00) begin
      miscompares++;
      $display("FAIL straight_10: winner=%b required 00", w[0]);
    end
    press(1, 0, 0, 0);
    vectors++;
    if (nl[0] !== 8'd11 || nr[0] !== 8'd9 || w[0] !== 2'b01) begin
      miscompares++;
      $display("FAIL straight_11: got %0d-%0d w=%b required 11-9 w=01", nl[0], nr[0], w[0]);
    end
  endtask

  task automatic test_random();
    int sel;
    press(0, 0, 1, 0);
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 11);
      if (sel == 0)      press(0, 0, 1, $urandom_range(0, 3));
      else if (sel == 1) press(1, 1, 0, $urandom_range(0, 3));
      else if (sel < 7)  press(1, 0, 0, $urandom_range(0, 3));
      else               press(0, 1, 0, $urandom_range(0, 3));
    end
  endtask

  task automatic test_saturation();
    press(0, 0, 1, 0);
    for (int i = 0; i < 254; i++) begin press(1, 0, 0, 0); press(0, 1, 0, 0); end
    press(1, 0, 0, 0);
    vectors++;
    if (nl[1] !== 8'd255 || nr[1] !== 8'd254 || w[1] !== 2'b00) begin
      miscompares++;
      $display("FAIL sat_255_254: got %0d-%0d w=%b required 255-254 w=00", nl[1], nr[1], w[1]);
    end
    press(1, 0, 0, 0);
    vectors++;
    if (nl[1] !== 8'd255 || nr[1] !== 8'd254) begin
      miscompares++;
      $display("FAIL sat_hold: got %0d-%0d required 255-254", nl[1], nr[1]);
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_async_reset();
    test_simultaneous();
    test_win_by_two();
    test_straight_win();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
# score_keeper

Two-player scoreboard that sits directly upstream of the two-digit-group seven-segment display driver. It debounces three push buttons and keeps a left and a right score. It applies an win-by-two game rule and presents the scores as 8-bit binary values. Its `num_left`/`num_right` outputs connect straight to the display driver's inputs of the same name, and the display driver does the binary-to-BCD conversion.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive cycles a synchronized button level must differ from the current stable level before the stable level flips. Legal range 2..2^24-1.
- `WIN_SCORE`, default 11: minimum score needed to win. Legal range 2..254.

Ports:
- `clk`  input  1  system clock.
- `rst`  input  1  reset, asynchronous, active-low; all state clears while low.
- `btn_left`  input  1  raw, asynchronous, bouncy button; a press awards a point to the left player.
- `btn_right`  input  1  raw button; a press awards a point to the right player.
- `btn_clear`  input  1  raw button; a press starts a new game.
- `num_left`  output  8  left score, unsigned binary.
- `num_right`  output  8  right score, unsigned binary.
- `winner`  output  2  `2'b00` none, `2'b01` left, `2'b10` right.
- `point`  output  1  one-cycle pulse on every accepted score change.

## Operation
- **Button conditioning.** Each button goes through its own debouncer instance.
  - The raw input passes through a 2-FF synchronizer.
  - A counter counts cycles where the synchronized level differs from the stable level. It resets to 0 on any cycle where they match.
  - When the count reaches `DEBOUNCE_CYCLES`, the stable level flips.
  - A registered rising-edge detector on the stable level produces a one-cycle press pulse. Releases produce no pulse.
- **States.** Two states: `PLAY` and `DONE`. The reset state is `PLAY`.
- **Priority in every cycle.**
  1. The clear pulse goes to `PLAY` and sets both scores to 0 and `winner` to 00. This applies in either state and overrides any simultaneous left or right pulse.
  2. If left and right pulses arrive in the same cycle, both are discarded: no score change and no `point` pulse.
  3. A single left or right pulse in `PLAY` increments that side's score.
- **Saturation.** A score of 255 does not wrap. A pulse for a side already at 255 is ignored and produces no `point` pulse.
- **Win check.** Evaluated on the incremented values in the same cycle as the increment. If a side's score is at least `WIN_SCORE` and exceeds the other side's by at least 2, the block moves to `DONE` and `winner` is set to that side.
- **Win arithmetic.** The lead is computed in 9-bit signed arithmetic so there is no underflow.
- **DONE state.** Left and right pulses are ignored and scores freeze. Only a clear pulse leaves `DONE`.
- **Reset mid-debounce.** Counters, synchronizers and stable levels clear to 0. A button held through reset release is seen as a fresh press after the full debounce time.

## Timing
- **Reset values.** `num_left` = 0, `num_right` = 0, `winner` = 00, `point` = 0, state `PLAY`.
- **Registered outputs.** All outputs come directly from flops; there is no combinational path from inputs to outputs.
- **Latency.** Let edge 0 be the first clock edge that samples a raw button high, with the button then held clean.
  - The synchronized level is high after edge 1.
  - The stable level flips at edge 1+`DEBOUNCE_CYCLES`.
  - The press pulse is high for the cycle after edge 2+`DEBOUNCE_CYCLES`.
  - `num_*`, `winner` and `point` update at edge 3+`DEBOUNCE_CYCLES`.
- **Glitch rejection.** Bounce shorter than `DEBOUNCE_CYCLES` consecutive cycles never flips the stable level.
- **Repeat rate.** A held button produces exactly one point. Back-to-back presses can score at most once every 2·`DEBOUNCE_CYCLES`+2 cycles.

## Structure
- **Shared package `score_pkg`.** Holds:
  - the state encoding (`PLAY`, `DONE`);
  - the `winner` codes (`WIN_NONE`, `WIN_LEFT`, `WIN_RIGHT`);
  - the constant `SCORE_MAX` = 8'd255.
- **Sub-module `btn_debounce`.** Parameterized by `DEBOUNCE_CYCLES`; ports `clk`, `rst`, `btn_raw`, `press`. It is instantiated three times.
- **Top level.** Holds only the FSM, the score registers and the win comparator.

## Test plan
All scenarios run with `DEBOUNCE_CYCLES`=4 and `WIN_SCORE`=11.
- **Reset.** Hold `rst` low, then release with all buttons low → all outputs 0 and `winner`=00. Assert `rst` low mid-game with `num_left`=5 → `num_left` is 0 on the next sampled cycle, asynchronously.
- **Debounce.** Toggle `btn_left` every 2 cycles for 20 cycles, then hold it high for 10 cycles → exactly one `point` pulse, `num_left`=1, and the update lands at edge 7 after the start of the clean hold.
- **Simultaneous presses.** Press left and right with identical timing → no `point`, scores unchanged. Press left and clear together from `num_left`=3 → scores 0/0, no `point`.
- **Win by two.**
  - Drive the score to 10–10, then left scores → 11–10, `winner`=00.
  - Left scores again → 12–10, `winner`=01, state `DONE`.
  - A further right press → scores stay 12–10, no `point`.
  - Clear → 0–0, `winner`=00.
- **Straight win.** Score from 0–9 to 11–9 for left → `winner`=01 exactly on the 11th left point.
- **Saturation.** With `WIN_SCORE` set to 254, force 255–254 by alternating points, then press left → `num_left` stays 255, no `point`, no wrap to 0.
